// File: rtl/lstm_seq_ctrl_if.sv
// Handshake and datapath-control bundle between the LSTM sequencer and its surroundings.
// master = sequencer side, slave = input source, LSTM layer, perceptron and result sink.
interface lstm_seq_ctrl_if #(
  parameter int BITWIDTH = 18,
  parameter int INPUT_SZ = 2,
  parameter int SEQ_LEN  = 8
);
  localparam int STEP_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;

  logic                         in_valid;
  logic                         in_ready;
  logic [INPUT_SZ*BITWIDTH-1:0] in_data;

  logic                         net_reset;
  logic                         net_newSample;
  logic [INPUT_SZ*BITWIDTH-1:0] net_inputVec;
  logic                         net_dataReady;

  logic                         perc_reset;
  logic                         perc_dataReady;
  logic [BITWIDTH-1:0]          perc_result;

  logic                         out_valid;
  logic                         out_ready;
  logic [BITWIDTH-1:0]          out_data;
  logic [STEP_W-1:0]            out_step;
  logic                         out_last;

  logic                         err_timeout;
  logic                         err_clear;

  modport master (
    input  in_valid, in_data, net_dataReady, perc_dataReady, perc_result, out_ready, err_clear,
    output in_ready, net_reset, net_newSample, net_inputVec, perc_reset,
           out_valid, out_data, out_step, out_last, err_timeout
  );

  modport slave (
    output in_valid, in_data, net_dataReady, perc_dataReady, perc_result, out_ready, err_clear,
    input  in_ready, net_reset, net_newSample, net_inputVec, perc_reset,
           out_valid, out_data, out_step, out_last, err_timeout
  );
endinterface

// File: rtl/lstm_seq_ctrl.sv
// LSTM inference sequencer: accept vector, launch layer, enable perceptron, emit one result per step.
// Accept-to-launch 1 cycle; result held in S_OUT until out_ready; watchdog aborts stalled steps.
module lstm_seq_ctrl #(
  parameter int BITWIDTH       = 18,
  parameter int INPUT_SZ       = 2,
  parameter int SEQ_LEN        = 8,
  parameter int SEQ_RST_CYCLES = 4,
  parameter int TIMEOUT        = 1023
) (
  input  logic             clock,
  input  logic             reset,
  lstm_seq_ctrl_if.master  bus
);
  localparam int STEP_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam int WD_W   = $clog2(TIMEOUT + 1);
  localparam int RC_W   = (SEQ_RST_CYCLES > 1) ? $clog2(SEQ_RST_CYCLES) : 1;

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(SEQ_LEN - 1);
  localparam logic [STEP_W-1:0] PREV_STEP = STEP_W'(SEQ_LEN - 2);
  localparam logic [RC_W-1:0]   RC_LAST   = RC_W'(SEQ_RST_CYCLES - 1);
  localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_SEQRST, S_IDLE, S_LAUNCH, S_WAITN, S_GAP, S_WAITP, S_OUT
  } state_t;

  state_t            state;
  logic [RC_W-1:0]   rstCnt;
  logic [WD_W-1:0]   wdCnt;
  logic [STEP_W-1:0] step;
  logic              netDrQ, netDrQ2, percDrQ, percDrQ2;
  logic              netRise, percRise, wdExpired;

  // Both done strobes pass through a register before edge detection, so only fresh rises count.
  assign netRise   = netDrQ & ~netDrQ2;
  assign percRise  = percDrQ & ~percDrQ2;
  assign wdExpired = (wdCnt == WD_LAST);

  assign bus.out_step = step;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state             <= S_SEQRST;
      rstCnt            <= '0;
      wdCnt             <= '0;
      step              <= '0;
      netDrQ            <= 1'b0;
      netDrQ2           <= 1'b0;
      percDrQ           <= 1'b0;
      percDrQ2          <= 1'b0;
      bus.net_reset     <= 1'b1;
      bus.perc_reset    <= 1'b1;
      bus.net_newSample <= 1'b0;
      bus.in_ready      <= 1'b0;
      bus.out_valid     <= 1'b0;
      bus.out_last      <= 1'b0;
      bus.err_timeout   <= 1'b0;
      bus.out_data      <= '0;
      bus.net_inputVec  <= '0;
    end else begin
      netDrQ   <= bus.net_dataReady;
      netDrQ2  <= netDrQ;
      percDrQ  <= bus.perc_dataReady;
      percDrQ2 <= percDrQ;

      // A watchdog abort below overrides this clear when both land together.
      if (bus.err_clear) bus.err_timeout <= 1'b0;

      case (state)
        S_SEQRST: begin
          if (rstCnt == RC_LAST) begin
            state         <= S_IDLE;
            bus.net_reset <= 1'b0;
            bus.in_ready  <= 1'b1;
          end else begin
            rstCnt <= rstCnt + 1'b1;
          end
        end

        S_IDLE: begin
          if (bus.in_valid) begin
            bus.net_inputVec  <= bus.in_data;
            bus.in_ready      <= 1'b0;
            bus.net_newSample <= 1'b1;
            state             <= S_LAUNCH;
          end
        end

        S_LAUNCH: begin
          bus.net_newSample <= 1'b0;
          wdCnt             <= '0;
          state             <= S_WAITN;
        end

        S_WAITN: begin
          if (netRise) begin
            state <= S_GAP;
          end else if (wdExpired) begin
            bus.err_timeout <= 1'b1;
            bus.net_reset   <= 1'b1;
            bus.perc_reset  <= 1'b1;
            bus.out_last    <= 1'b0;
            step            <= '0;
            rstCnt          <= '0;
            state           <= S_SEQRST;
          end else begin
            wdCnt <= wdCnt + 1'b1;
          end
        end

        S_GAP: begin
          bus.perc_reset <= 1'b0;
          wdCnt          <= '0;
          state          <= S_WAITP;
        end

        S_WAITP: begin
          if (percRise) begin
            bus.out_data   <= bus.perc_result;
            bus.out_valid  <= 1'b1;
            bus.perc_reset <= 1'b1;
            state          <= S_OUT;
          end else if (wdExpired) begin
            bus.err_timeout <= 1'b1;
            bus.net_reset   <= 1'b1;
            bus.perc_reset  <= 1'b1;
            bus.out_last    <= 1'b0;
            step            <= '0;
            rstCnt          <= '0;
            state           <= S_SEQRST;
          end else begin
            wdCnt <= wdCnt + 1'b1;
          end
        end

        S_OUT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            if (step == LAST_STEP) begin
              step          <= '0;
              bus.out_last  <= 1'b0;
              bus.net_reset <= 1'b1;
              rstCnt        <= '0;
              state         <= S_SEQRST;
            end else begin
              step         <= step + 1'b1;
              bus.out_last <= (step == PREV_STEP);
              bus.in_ready <= 1'b1;
              state        <= S_IDLE;
            end
          end
        end

        default: state <= S_SEQRST;
      endcase
    end
  end
endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// Directed bench for lstm_seq_ctrl: reset, full sequence, output stall, watchdog, stale strobe, mid-run reset.
module tb_lstm_seq_ctrl;
  localparam int BW = 18;
  localparam int IS = 2;
  localparam int SL = 8;

  logic clock;
  logic reset;
  int   nAsserts = 0;
  int   nFails   = 0;
  int   nResults = 0;

  lstm_seq_ctrl_if #(.BITWIDTH(BW), .INPUT_SZ(IS), .SEQ_LEN(SL)) bus ();

  lstm_seq_ctrl #(
    .BITWIDTH(BW), .INPUT_SZ(IS), .SEQ_LEN(SL), .SEQ_RST_CYCLES(4), .TIMEOUT(1023)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic waitReady();
    for (int i = 0; i < 20 && bus.in_ready !== 1'b1; i++) tick();
    check("wait_in_ready", bus.in_ready, 1);
  endtask

  task automatic waitPercEnable();
    for (int i = 0; i < 10 && bus.perc_reset !== 1'b0; i++) tick();
    check("wait_perc_enable", bus.perc_reset, 0);
  endtask

  // One timestep through the layer/perceptron model; optional output stall and stale-strobe handling.
  task automatic runStep(input logic [IS*BW-1:0] vec, input logic [BW-1:0] res, input int expStep,
                         input int outHold, input bit staleIn, input bit keepHigh);
    bus.out_ready = (outHold == 0);
    waitReady();
    bus.in_valid = 1'b1;
    bus.in_data  = vec;
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    check("launch_pulse", bus.net_newSample, 1);
    check("launch_vec", bus.net_inputVec, vec);
    check("launch_in_ready", bus.in_ready, 0);
    tick();
    check("launch_one_cycle", bus.net_newSample, 0);
    repeat (18) tick();
    if (staleIn) begin
      check("stale_no_advance", bus.perc_reset, 1);
      check("stale_no_valid", bus.out_valid, 0);
      bus.net_dataReady = 1'b0;
      tick();
    end
    bus.net_dataReady = 1'b1;
    tick();
    if (!keepHigh) bus.net_dataReady = 1'b0;
    waitPercEnable();
    repeat (5) tick();
    bus.perc_result    = res;
    bus.perc_dataReady = 1'b1;
    tick();
    bus.perc_dataReady = 1'b0;
    check("out_valid_early", bus.out_valid, 0);
    tick();
    check("out_valid", bus.out_valid, 1);
    check("out_data", bus.out_data, res);
    check("out_step", bus.out_step, expStep);
    check("out_last", bus.out_last, (expStep == SL - 1));
    if (bus.out_valid === 1'b1) nResults++;
    for (int i = 0; i < outHold; i++) begin
      tick();
      check("hold_valid", bus.out_valid, 1);
      check("hold_data", bus.out_data, res);
      check("hold_step", bus.out_step, expStep);
      check("hold_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    tick();
    check("out_consumed", bus.out_valid, 0);
  endtask

  initial begin
    int  n;
    bit  sawValid;
    logic [IS*BW-1:0] vec;

    reset = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    bus.net_dataReady = 1'b0; bus.perc_dataReady = 1'b0; bus.perc_result = '0;
    bus.out_ready = 1'b1; bus.err_clear = 1'b0;
    repeat (3) tick();

    check("rst_net_reset", bus.net_reset, 1);
    check("rst_perc_reset", bus.perc_reset, 1);
    check("rst_new_sample", bus.net_newSample, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_err", bus.err_timeout, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_step", bus.out_step, 0);
    check("rst_input_vec", bus.net_inputVec, 0);

    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("seqrst_net_reset", bus.net_reset, 1);
      check("seqrst_in_ready", bus.in_ready, 0);
      tick();
    end
    check("seqrst_done_net_reset", bus.net_reset, 0);
    check("seqrst_done_in_ready", bus.in_ready, 1);

    // Full sequence of eight steps.
    for (int k = 0; k < SL; k++) begin
      vec = (k == 0) ? {18'h00800, 18'h00400} : {18'(k << 8), 18'(k << 4)};
      runStep(vec, 18'(18'h20000 | (k * 18'h111)), k, 0, 1'b0, 1'b0);
    end
    check("result_count", nResults, SL);
    for (int i = 0; i < 4; i++) begin
      check("endseq_net_reset", bus.net_reset, 1);
      check("endseq_in_ready", bus.in_ready, 0);
      tick();
    end
    check("endseq_in_ready_back", bus.in_ready, 1);

    // Output stall, then a layer strobe left high across two steps.
    runStep({18'h00001, 18'h00002}, 18'h01234, 0, 10, 1'b0, 1'b0);
    runStep({18'h00003, 18'h00004}, 18'h02345, 1, 0, 1'b0, 1'b1);
    runStep({18'h00005, 18'h00006}, 18'h03456, 2, 0, 1'b1, 1'b0);

    // Watchdog: layer never reports done.
    waitReady();
    bus.in_valid = 1'b1; bus.in_data = {18'h00007, 18'h00008};
    tick();
    bus.in_valid = 1'b0;
    check("wd_launch", bus.net_newSample, 1);
    n = 0; sawValid = 1'b0;
    while (bus.err_timeout !== 1'b1 && n < 1100) begin
      tick();
      n++;
      if (bus.out_valid === 1'b1) sawValid = 1'b1;
    end
    check("wd_cycles", n, 1024);
    check("wd_no_valid", sawValid, 0);
    check("wd_err", bus.err_timeout, 1);
    check("wd_net_reset", bus.net_reset, 1);
    check("wd_step", bus.out_step, 0);
    tick();
    check("wd_err_sticky", bus.err_timeout, 1);
    bus.err_clear = 1'b1;
    tick();
    bus.err_clear = 1'b0;
    check("wd_err_cleared", bus.err_timeout, 0);
    runStep({18'h00009, 18'h0000A}, 18'h04567, 0, 0, 1'b0, 1'b0);

    // Asynchronous reset while the perceptron is enabled.
    waitReady();
    bus.in_valid = 1'b1; bus.in_data = {18'h0000B, 18'h0000C};
    tick();
    bus.in_valid = 1'b0;
    repeat (5) tick();
    bus.net_dataReady = 1'b1;
    tick();
    bus.net_dataReady = 1'b0;
    waitPercEnable();
    check("mid_step_before", bus.out_step, 1);
    reset = 1'b0;
    #1;
    check("mid_rst_perc_reset", bus.perc_reset, 1);
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_step", bus.out_step, 0);
    check("mid_rst_net_reset", bus.net_reset, 1);
    tick();
    reset = 1'b1;
    runStep({18'h0000D, 18'h0000E}, 18'h05678, 0, 0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end
endmodule
